// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- style BIST sequencer (up{w0}; up{r0,w1}; down{r1,w0}; down{r0})
// driving a single-port sync RAM and recording the first read mismatch.
module ram_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_C, M1_W, M2_R, M2_C, M2_W, M3_R, M3_C, DONE
  } state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] ONES = '1;
  state_t state, nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic last, first, launch, cmp, mism;
  assign last   = mem_addr == LAST;
  assign first  = mem_addr == '0;
  assign launch = (state == IDLE || state == DONE) && start;
  assign cmp    = state inside {M1_C, M2_C, M3_C};
  // Read data is registered by the RAM, so it is valid during the C cycle.
  assign mism   = cmp && mem_rdata != (state == M2_C ? ONES : '0);
  always_comb begin
    nxt      = state;
    nxt_addr = mem_addr;
    case (state)
      IDLE, DONE: if (start) begin nxt = M0_W; nxt_addr = '0; end
      M0_W: begin nxt = last ? M1_R : M0_W; nxt_addr = last ? '0 : mem_addr + 1'b1; end
      M1_R: nxt = M1_C;
      M1_C: nxt = M1_W;
      M1_W: begin nxt = last ? M2_R : M1_R; nxt_addr = last ? LAST : mem_addr + 1'b1; end
      M2_R: nxt = M2_C;
      M2_C: nxt = M2_W;
      M2_W: begin nxt = first ? M3_R : M2_R; nxt_addr = first ? LAST : mem_addr - 1'b1; end
      M3_R: nxt = M3_C;
      M3_C: begin nxt = first ? DONE : M3_R; nxt_addr = first ? mem_addr : mem_addr - 1'b1; end
      default: begin nxt = IDLE; nxt_addr = '0; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= nxt;
      mem_addr  <= nxt_addr;
      mem_we    <= nxt inside {M0_W, M1_W, M2_W};
      mem_wdata <= nxt == M1_W ? ONES : '0;
      busy      <= !(nxt inside {IDLE, DONE});
      done      <= nxt == DONE;
      if (launch) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mism && !fail) begin
        fail      <= 1'b1;
        fail_addr <= mem_addr;
        fail_data <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: checks the BIST against a March-sequence model driving a
// behavioural fault-injectable 8x4 RAM.
module tb_ram_march_bist;
  localparam int AW = 4, DW = 4, D = 8, N = 72;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic mem_we, busy, done, fail;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fail_data;
  logic [DW-1:0] ram [D];
  logic [DW-1:0] sa1 [D];
  logic [DW-1:0] sa0 [D];
  logic e_we [N];
  logic e_cmp [N];
  logic [AW-1:0] e_addr [N];
  logic [DW-1:0] e_wd [N];
  logic [DW-1:0] e_val [N];
  int nops = 0;
  int checks = 0, errors = 0;
  int ff_idx;
  logic [AW-1:0] m_fa;
  logic [DW-1:0] m_fd;

  always #5 clk = ~clk;

  ram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[2:0]] <= mem_wdata;
    else mem_rdata <= (ram[mem_addr[2:0]] | sa1[mem_addr[2:0]]) & ~sa0[mem_addr[2:0]];
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic add(input logic we, input int a, input logic [DW-1:0] wd,
                     input logic c, input logic [DW-1:0] v);
    e_we[nops] = we; e_addr[nops] = AW'(a); e_wd[nops] = wd; e_cmp[nops] = c; e_val[nops] = v;
    nops++;
  endtask

  // Bus activity of one March run: write cycles, read-issue cycles, compare cycles.
  task automatic build();
    for (int a = 0; a < D; a++) add(1, a, 4'h0, 0, 4'h0);
    for (int a = 0; a < D; a++) begin add(0, a, 4'h0, 0, 4'h0); add(0, a, 4'h0, 1, 4'h0); add(1, a, 4'hF, 0, 4'h0); end
    for (int a = D-1; a >= 0; a--) begin add(0, a, 4'h0, 0, 4'h0); add(0, a, 4'h0, 1, 4'hF); add(1, a, 4'h0, 0, 4'h0); end
    for (int a = D-1; a >= 0; a--) begin add(0, a, 4'h0, 0, 4'h0); add(0, a, 4'h0, 1, 4'h0); end
  endtask

  task automatic model();
    logic [DW-1:0] m [D];
    logic [DW-1:0] rd;
    ff_idx = N + 1; m_fa = '0; m_fd = '0;
    for (int i = 0; i < N; i++) begin
      if (e_we[i]) m[e_addr[i][2:0]] = e_wd[i];
      else if (e_cmp[i]) begin
        rd = (m[e_addr[i][2:0]] | sa1[e_addr[i][2:0]]) & ~sa0[e_addr[i][2:0]];
        if (rd != e_val[i] && ff_idx > N) begin ff_idx = i; m_fa = e_addr[i]; m_fd = rd; end
      end
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < D; a++) begin sa1[a] = '0; sa0[a] = '0; end
  endtask

  task automatic go(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic check_run(input int n);
    model();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("c%0d we", k), int'(mem_we), int'(e_we[k]));
      chk($sformatf("c%0d addr", k), int'(mem_addr), int'(e_addr[k]));
      chk($sformatf("c%0d wdata", k), int'(mem_wdata), int'(e_wd[k]));
      chk($sformatf("c%0d busy", k), int'(busy), 1);
      chk($sformatf("c%0d done", k), int'(done), 0);
      chk($sformatf("c%0d fail", k), int'(fail), int'(ff_idx < k));
      @(negedge clk);
    end
  endtask

  task automatic check_done();
    chk("done", int'(done), 1);
    chk("busy at done", int'(busy), 0);
    chk("we at done", int'(mem_we), 0);
    chk("wdata at done", int'(mem_wdata), 0);
    chk("fail at done", int'(fail), int'(ff_idx < N));
    chk("fail_addr", int'(fail_addr), int'(m_fa));
    chk("fail_data", int'(fail_data), int'(m_fd));
  endtask

  initial begin
    build();
    clear_faults();
    @(negedge clk); @(negedge clk);
    chk("rst we", int'(mem_we), 0);
    chk("rst addr", int'(mem_addr), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst fail", int'(fail), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", int'(busy), 0);

    // 1: good RAM
    go(0); check_run(N); check_done();
    chk("good fail", int'(fail), 0);
    for (int a = 0; a < D; a++) chk($sformatf("ram[%0d]", a), int'(ram[a]), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done held", int'(done), 1);
    end

    // 2: stuck-at-1 bit0 @3, found in M1
    sa1[3] = 4'b0001;
    go(0); check_run(N); check_done();
    chk("t2 model idx", ff_idx, 18);
    chk("t2 fail", int'(fail), 1);
    chk("t2 fail_addr", int'(fail_addr), 3);
    chk("t2 fail_data", int'(fail_data), 4'b0001);

    // 3: stuck-at-0 bit3 @6, found in M2
    clear_faults(); sa0[6] = 4'b1000;
    go(0); check_run(N); check_done();
    chk("t3 fail", int'(fail), 1);
    chk("t3 fail_addr", int'(fail_addr), 6);
    chk("t3 fail_data", int'(fail_data), 4'b0111);

    // 4: two faults, first one wins
    clear_faults(); sa1[2] = 4'b0010; sa1[5] = 4'b0010;
    go(0); check_run(N); check_done();
    chk("t4 fail_addr", int'(fail_addr), 2);
    chk("t4 fail_data", int'(fail_data), 4'b0010);

    // 5: reset mid-run with a fault already latched
    clear_faults(); sa1[3] = 4'b0001;
    go(0); check_run(30);
    chk("t5 fail before rst", int'(fail), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5 we", int'(mem_we), 0);
    chk("t5 busy", int'(busy), 0);
    chk("t5 done", int'(done), 0);
    chk("t5 fail", int'(fail), 0);
    chk("t5 fail_addr", int'(fail_addr), 0);
    rst_n = 1'b1;
    clear_faults();
    @(negedge clk);
    go(0); check_run(N); check_done();

    // 6: start held high through the run, restart from DONE
    sa1[4] = 4'b0100;
    go(1); check_run(N); check_done();
    chk("t6 fail_addr", int'(fail_addr), 4);
    @(negedge clk);
    start = 1'b0;
    check_run(N); check_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
